// File: rtl/end_game.sv
// rtl/end_game.sv - Snake game-over detector with sticky flag and cause code.
// Optional macro BOUNDARY_CHECK_EN enables the out-of-bounds term.
module end_game #(
  parameter int NSEG  = 5,
  parameter int SEG_W = 40,
  parameter int MAX_X = 639,
  parameter int MAX_Y = 479
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  update,
  input  logic [SEG_W-1:0]      head,
  input  logic [NSEG*SEG_W-1:0] body,
  output logic                  isOver,
  output logic [1:0]            over_cause
);

  localparam int YW = SEG_W / 2;
  localparam int XW = SEG_W - YW;

`ifdef BOUNDARY_CHECK_EN
  localparam bit OOB_EN = 1'b1;
`else
  localparam bit OOB_EN = 1'b0;
`endif

  localparam logic [XW-1:0] LIM_X = XW'(MAX_X);
  localparam logic [YW-1:0] LIM_Y = YW'(MAX_Y);

  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic          hit_body;
  logic          oob;

  assign head_x = head[SEG_W-1:YW];
  assign head_y = head[YW-1:0];

  // Every segment is live, including all-zero ones at (0,0).
  always_comb begin
    hit_body = 1'b0;
    for (int i = 0; i < NSEG; i++) begin
      if (body[i*SEG_W +: SEG_W] == head) hit_body = 1'b1;
    end
  end

  // With the feature off this folds to a constant 0.
  assign oob = OOB_EN && ((head_x > LIM_X) || (head_y > LIM_Y));

  always_ff @(posedge clk) begin
    if (rst) begin
      isOver     <= 1'b0;
      over_cause <= 2'b00;
    end else if (update && !isOver && (hit_body || oob)) begin
      isOver     <= 1'b1;
      over_cause <= {oob, hit_body};
    end
  end

endmodule

// File: tb/tb_end_game.sv
// tb/tb_end_game.sv - Randomized self-checking bench for end_game.
// Honours BOUNDARY_CHECK_EN the same way as the design build.
module tb_end_game;

  localparam int NSEG  = 5;
  localparam int SEG_W = 40;

`ifdef BOUNDARY_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  update;
  logic [SEG_W-1:0]      head;
  logic [NSEG*SEG_W-1:0] body;
  logic                  isOver;
  logic [1:0]            over_cause;

  int errors = 0;
  int checks = 0;

  bit       m_over;
  bit [1:0] m_cause;

  end_game #(.NSEG(NSEG), .SEG_W(SEG_W), .MAX_X(639), .MAX_Y(479)) dut (
    .clk        (clk),
    .rst        (rst),
    .update     (update),
    .head       (head),
    .body       (body),
    .isOver     (isOver),
    .over_cause (over_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [39:0] xy(input int x, input int y);
    logic [19:0] xs;
    logic [19:0] ys;
    xs = x[19:0];
    ys = y[19:0];
    return {xs, ys};
  endfunction

  function automatic logic [199:0] mk_body(input logic [39:0] s0, input logic [39:0] s1,
                                           input logic [39:0] s2, input logic [39:0] s3,
                                           input logic [39:0] s4);
    return {s4, s3, s2, s1, s0};
  endfunction

  // Reference: game ends on the first enabled evaluation where the head
  // sits on any segment or outside the 0..639 x 0..479 field.
  task automatic model(input bit r, input bit u, input logic [39:0] h, input logic [199:0] b);
    longint unsigned hv;
    longint unsigned xv;
    longint unsigned yv;
    bit hit;
    bit out;
    if (r) begin
      m_over  = 1'b0;
      m_cause = 2'b00;
    end else if (u && !m_over) begin
      hit = 1'b0;
      for (int i = 0; i < NSEG; i++)
        if (b[i*SEG_W +: SEG_W] == h) hit = 1'b1;
      hv  = longint'(h);
      xv  = hv / 1048576;
      yv  = hv % 1048576;
      out = BC && (xv > 639 || yv > 479);
      if (hit || out) begin
        m_over  = 1'b1;
        m_cause = {out, hit};
      end
    end
  endtask

  task automatic step(input string tag, input bit r, input bit u,
                      input logic [39:0] h, input logic [199:0] b);
    rst    = r;
    update = u;
    head   = h;
    body   = b;
    @(posedge clk);
    model(r, u, h, b);
    #1;
    check({tag, ".isOver"}, 32'(isOver), 32'(m_over));
    check({tag, ".cause"}, 32'(over_cause), 32'(m_cause));
  endtask

  initial begin
    logic [199:0] line_body;
    logic [39:0]  segs [NSEG];
    logic [39:0]  h;
    bit           r;
    bit           u;

    rst = 1'b1; update = 1'b0; head = '0; body = '0;
    m_over = 1'b0; m_cause = 2'b00;

    step("reset", 1'b1, 1'b1, 40'd0, 200'd0);
    check("reset.const", {30'd0, over_cause, isOver}, 32'd0);
    step("self_zero", 1'b0, 1'b1, 40'd0, 200'd0);
    check("self_zero.const", {30'd0, over_cause, isOver}, 32'b011);
    step("sticky", 1'b0, 1'b1, 40'hFF_FFFF_FFFF, 200'd0);

    step("rst2", 1'b1, 1'b0, 40'd0, 200'd0);
    step("oob_max", 1'b0, 1'b1, 40'hFF_FFFF_FFFF, 200'd0);
    check("oob_max.const", {30'd0, over_cause, isOver}, BC ? 32'b101 : 32'd0);
    step("oob_sticky", 1'b0, 1'b1, 40'd0, 200'd0);

    step("rst3", 1'b1, 1'b0, 40'd0, 200'd0);
    line_body = mk_body(xy(11,10), xy(12,10), xy(13,10), xy(14,10), xy(15,10));
    for (int i = 0; i < 5; i++) step("no_hit", 1'b0, 1'b1, xy(10,10), line_body);
    step("edge_ok", 1'b0, 1'b1, xy(639,479), line_body);
    check("edge_ok.const", 32'(isOver), 32'd0);
    step("x640", 1'b0, 1'b1, xy(640,10), line_body);

    step("rst4", 1'b1, 1'b0, 40'd0, 200'd0);
    step("y480", 1'b0, 1'b1, xy(5,480), line_body);

    step("rst5", 1'b1, 1'b0, 40'd0, 200'd0);
    for (int i = 0; i < 3; i++) step("gated", 1'b0, 1'b0, xy(13,10), line_body);
    check("gated.const", 32'(isOver), 32'd0);
    step("ungated", 1'b0, 1'b1, xy(13,10), line_body);

    step("rst6", 1'b1, 1'b0, 40'd0, 200'd0);
    step("seg4", 1'b0, 1'b1, xy(5,7), mk_body(xy(1,1), xy(2,2), xy(3,3), xy(4,4), xy(5,7)));
    check("seg4.const", 32'(isOver), 32'd1);

    step("rst7", 1'b1, 1'b0, 40'd0, 200'd0);
    step("both", 1'b0, 1'b1, xy(700,3), mk_body(xy(1,1), xy(700,3), xy(3,3), xy(4,4), xy(5,5)));
    check("both.const", 32'(over_cause), BC ? 32'b11 : 32'b01);

    step("rst_prio", 1'b1, 1'b1, xy(700,3), mk_body(xy(1,1), xy(700,3), xy(3,3), xy(4,4), xy(5,5)));

    // Coordinates cluster around the field edges so hits, misses and
    // boundary crossings all occur often.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NSEG; i++)
        segs[i] = xy(634 + $urandom_range(0, 10), 474 + $urandom_range(0, 10));
      if ($urandom_range(0, 3) == 0)
        h = segs[$urandom_range(0, NSEG-1)];
      else if ($urandom_range(0, 15) == 0)
        h = {$urandom(), $urandom()};
      else
        h = xy(634 + $urandom_range(0, 10), 474 + $urandom_range(0, 10));
      r = ($urandom_range(0, 9) == 0);
      u = ($urandom_range(0, 3) != 0);
      step("rand", r, u, h, mk_body(segs[0], segs[1], segs[2], segs[3], segs[4]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
